// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU function codes, flag layout and command record
package alu_pkg;

    localparam logic [3:0] FUNC_ADD = 4'b0000;
    localparam logic [3:0] FUNC_SUB = 4'b0001;
    localparam logic [3:0] FUNC_MUL = 4'b0010;
    localparam logic [3:0] FUNC_DIV = 4'b0011;
    localparam logic [3:0] FUNC_AND = 4'b0100;
    localparam logic [3:0] FUNC_OR  = 4'b0101;
    localparam logic [3:0] FUNC_XOR = 4'b0110;
    localparam logic [3:0] FUNC_NOT = 4'b0111;
    localparam logic [3:0] FUNC_SHL = 4'b1000;
    localparam logic [3:0] FUNC_SHR = 4'b1001;
    localparam logic [3:0] FUNC_SRA = 4'b1010;
    localparam logic [3:0] FUNC_ROL = 4'b1011;
    localparam logic [3:0] FUNC_ROR = 4'b1100;
    localparam logic [3:0] FUNC_LT  = 4'b1101;
    localparam logic [3:0] FUNC_GT  = 4'b1110;
    localparam logic [3:0] FUNC_EQ  = 4'b1111;

    localparam int FLAG_CARRY  = 3;
    localparam int FLAG_ZR     = 2;
    localparam int FLAG_SIGN   = 1;
    localparam int FLAG_PARITY = 0;

    localparam logic [31:0] DIV0_RESULT = 32'hFFFF_FFFF;
    // All-ones result: no carry, non-zero, negative, even number of set bits.
    localparam logic [3:0]  DIV0_FLAGS  = 4'b0011;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  func;
    } alu_op_t;

    localparam int OP_W = $bits(alu_op_t);

    function automatic logic is_div_zero(input logic [3:0] func, input logic [31:0] b);
        return (func == FUNC_DIV) && (b == 32'd0);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous command FIFO with head-of-queue data exposed
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    // Push is judged against the registered count, so a pop in the same
    // cycle never makes room for a push into a full queue.
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - queues ALU commands, drives the external ALU, registers responses
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [31:0]              cmd_a,
    input  logic [31:0]              cmd_b,
    input  logic [3:0]               cmd_func,
    input  logic [TAG_W-1:0]         cmd_tag,
    output logic [31:0]              alu_a,
    output logic [31:0]              alu_b,
    output logic [3:0]               alu_func,
    input  logic [31:0]              alu_res,
    input  logic                     alu_carry,
    input  logic                     alu_zr,
    input  logic                     alu_sign,
    input  logic                     alu_parity,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_data,
    output logic [3:0]               rsp_flags,
    output logic                     rsp_err,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int ENTRY_W = OP_W + TAG_W;

    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head_data;
    alu_op_t            head_op;
    logic [TAG_W-1:0]   head_tag;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               issue;
    logic               div_zero;
    logic [3:0]         alu_flags;

    assign push_data           = {cmd_a, cmd_b, cmd_func, cmd_tag};
    assign {head_op, head_tag} = head_data;

    assign cmd_ready = ~fifo_full;
    assign push      = cmd_valid & cmd_ready;
    // The slot can take a new result when it is empty or being drained this cycle.
    assign issue     = ~fifo_empty & (~rsp_valid | rsp_ready);
    assign div_zero  = is_div_zero(head_op.func, head_op.b);

    always_comb begin
        alu_flags               = '0;
        alu_flags[FLAG_CARRY]   = alu_carry;
        alu_flags[FLAG_ZR]      = alu_zr;
        alu_flags[FLAG_SIGN]    = alu_sign;
        alu_flags[FLAG_PARITY]  = alu_parity;
    end

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_func = FUNC_ADD;
        if (!fifo_empty) begin
            alu_a    = head_op.a;
            alu_b    = head_op.b;
            alu_func = head_op.func;
        end
    end

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (issue),
        .head_data (head_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
            rsp_tag   <= '0;
        end else if (issue) begin
            rsp_valid <= 1'b1;
            rsp_tag   <= head_tag;
            if (div_zero) begin
                rsp_data  <= DIV0_RESULT;
                rsp_flags <= DIV0_FLAGS;
                rsp_err   <= 1'b1;
            end else begin
                rsp_data  <= alu_res;
                rsp_flags <= alu_flags;
                rsp_err   <= 1'b0;
            end
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed vector bench for alu_issue_stage with a behavioural ALU
module tb_alu_issue_stage;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [31:0]       cmd_a;
    logic [31:0]       cmd_b;
    logic [3:0]        cmd_func;
    logic [TAG_W-1:0]  cmd_tag;
    logic [31:0]       alu_a;
    logic [31:0]       alu_b;
    logic [3:0]        alu_func;
    logic [31:0]       alu_res;
    logic              alu_carry;
    logic              alu_zr;
    logic              alu_sign;
    logic              alu_parity;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic [3:0]        rsp_flags;
    logic              rsp_err;
    logic [TAG_W-1:0]  rsp_tag;
    logic [2:0]        fifo_count;

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [3:0]       func;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic [3:0]       flags;
        logic             err;
    } vec_t;

    vec_t vecs [8];
    vec_t bp   [6];
    vec_t add_v;
    vec_t exp_q [$];
    vec_t rx_e;
    int   rx_cyc_q [$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    alu_issue_stage #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_func   (cmd_func),
        .cmd_tag    (cmd_tag),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_func   (alu_func),
        .alu_res    (alu_res),
        .alu_carry  (alu_carry),
        .alu_zr     (alu_zr),
        .alu_sign   (alu_sign),
        .alu_parity (alu_parity),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err),
        .rsp_tag    (rsp_tag),
        .fifo_count (fifo_count)
    );

    // Behavioural ALU; divide by zero returns junk the stage must override.
    logic [32:0] m_wide;
    always_comb begin
        m_wide = '0;
        case (alu_func)
            FUNC_ADD: m_wide = {1'b0, alu_a} + {1'b0, alu_b};
            FUNC_SUB: m_wide = {1'b0, alu_a} - {1'b0, alu_b};
            FUNC_DIV: m_wide = {1'b0, (alu_b != 0) ? alu_a / alu_b : 32'hDEAD_BEEF};
            FUNC_AND: m_wide = {1'b0, alu_a & alu_b};
            FUNC_OR:  m_wide = {1'b0, alu_a | alu_b};
            FUNC_XOR: m_wide = {1'b0, alu_a ^ alu_b};
            FUNC_GT:  m_wide = {32'b0, alu_a > alu_b};
            FUNC_EQ:  m_wide = {32'b0, alu_a == alu_b};
            default:  m_wide = '0;
        endcase
    end
    assign alu_res    = m_wide[31:0];
    assign alu_carry  = m_wide[32];
    assign alu_zr     = (alu_res == 32'd0);
    assign alu_sign   = alu_res[31];
    assign alu_parity = ~^alu_res;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted response must match the next expected record.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && rsp_valid && rsp_ready) begin
            rx_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp: got tag %0h data %0h expected no response", rsp_tag, rsp_data);
            end else begin
                rx_e = exp_q.pop_front();
                check("rsp_tag",   rsp_tag,   rx_e.tag);
                check("rsp_data",  rsp_data,  rx_e.data);
                check("rsp_flags", rsp_flags, rx_e.flags);
                check("rsp_err",   rsp_err,   rx_e.err);
            end
        end
    end

    task automatic offer(input vec_t v);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_a     = v.a;
        cmd_b     = v.b;
        cmd_func  = v.func;
        cmd_tag   = v.tag;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL offer_timeout: got cmd_ready 0 expected 1 for tag %0h", v.tag);
        end
        @(posedge clk);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        check("drain_valid", rsp_valid, 0);
    endtask

    initial begin
        vecs[0] = '{a:32'd10,         b:32'd3,         func:FUNC_SUB, tag:4'd0, data:32'd7,         flags:4'b0000, err:1'b0};
        vecs[1] = '{a:32'hFFFF_0000,  b:32'h0F0F_0F0F, func:FUNC_XOR, tag:4'd1, data:32'hF0F0_0F0F, flags:4'b0011, err:1'b0};
        vecs[2] = '{a:32'd5,          b:32'd7,         func:FUNC_ADD, tag:4'd2, data:32'd12,        flags:4'b0001, err:1'b0};
        vecs[3] = '{a:32'hFFFF_FFFF,  b:32'd1,         func:FUNC_ADD, tag:4'd3, data:32'd0,         flags:4'b1101, err:1'b0};
        vecs[4] = '{a:32'd100,        b:32'd0,         func:FUNC_DIV, tag:4'd4, data:32'hFFFF_FFFF, flags:4'b0011, err:1'b1};
        vecs[5] = '{a:32'd100,        b:32'd7,         func:FUNC_DIV, tag:4'd5, data:32'd14,        flags:4'b0000, err:1'b0};
        vecs[6] = '{a:32'h1234,       b:32'h1234,      func:FUNC_EQ,  tag:4'd6, data:32'd1,         flags:4'b0000, err:1'b0};
        vecs[7] = '{a:32'd2,          b:32'd9,         func:FUNC_GT,  tag:4'd7, data:32'd0,         flags:4'b0101, err:1'b0};

        bp[0] = '{a:32'd1,    b:32'd1,    func:FUNC_ADD, tag:4'd9,  data:32'd2,         flags:4'b0000, err:1'b0};
        bp[1] = '{a:32'd3,    b:32'd5,    func:FUNC_SUB, tag:4'd10, data:32'hFFFF_FFFE, flags:4'b1010, err:1'b0};
        bp[2] = '{a:32'hF0,   b:32'h0F,   func:FUNC_OR,  tag:4'd11, data:32'hFF,        flags:4'b0001, err:1'b0};
        bp[3] = '{a:32'hFF,   b:32'h0F,   func:FUNC_AND, tag:4'd12, data:32'h0F,        flags:4'b0001, err:1'b0};
        bp[4] = '{a:32'd1,    b:32'd2,    func:FUNC_EQ,  tag:4'd13, data:32'd0,         flags:4'b0101, err:1'b0};
        bp[5] = '{a:32'd0,    b:32'd0,    func:FUNC_ADD, tag:4'd14, data:32'd0,         flags:4'b0101, err:1'b0};

        add_v = '{a:32'd5, b:32'd7, func:FUNC_ADD, tag:4'd3, data:32'd12, flags:4'b0001, err:1'b0};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_func  = '0;
        cmd_tag   = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_count", fifo_count, 0);
        check("reset_ready", cmd_ready, 1);
        check("reset_valid", rsp_valid, 0);
        check("reset_alu_a", alu_a, 0);
        rst_n = 1'b1;

        // Single add: minimum latency of two edges, head drives the ALU meanwhile.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_a = add_v.a; cmd_b = add_v.b; cmd_func = add_v.func; cmd_tag = add_v.tag;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("add_valid_edge1", rsp_valid, 0);
        check("add_count_edge1", fifo_count, 1);
        check("add_alu_a", alu_a, 5);
        check("add_alu_b", alu_b, 7);
        @(negedge clk);
        check("add_valid_edge2", rsp_valid, 1);
        check("add_data", rsp_data, 12);
        check("add_flags", rsp_flags, 4'b0001);
        check("add_err", rsp_err, 0);
        check("add_tag", rsp_tag, 3);
        check("add_empty_alu_a", alu_a, 0);
        check("add_empty_alu_func", alu_func, 0);
        @(negedge clk);
        check("add_hold_valid", rsp_valid, 1);
        check("add_hold_data", rsp_data, 12);
        exp_q.push_back(add_v);
        rsp_ready = 1'b1;
        wait_drain();

        // Back-to-back vector table with the consumer always ready.
        rx_cyc_q.delete();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(vecs[i]);
            offer(vecs[i]);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_drain();
        check("b2b_rx_count", rx_cyc_q.size(), 8);
        if (rx_cyc_q.size() == 8) begin
            check("b2b_one_per_cycle", rx_cyc_q[7] - rx_cyc_q[0], 7);
        end

        // Backpressure: one response held, FIFO full, sixth command refused.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(bp[i]);
            offer(bp[i]);
        end
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_a = bp[5].a; cmd_b = bp[5].b; cmd_func = bp[5].func; cmd_tag = bp[5].tag;
        check("bp_ready", cmd_ready, 0);
        check("bp_count", fifo_count, 4);
        check("bp_valid", rsp_valid, 1);
        check("bp_tag", rsp_tag, 9);
        repeat (2) @(negedge clk);
        check("bp_ready_hold", cmd_ready, 0);
        check("bp_data_hold", rsp_data, 2);
        check("bp_tag_hold", rsp_tag, 9);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_after_pop", cmd_ready, 1);
        check("bp_count_after_pop", fifo_count, 3);
        wait_drain();
        repeat (3) @(negedge clk);
        check("bp_no_extra", rsp_valid, 0);

        // Asynchronous reset with work in flight.
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(vecs[i]);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        check("prerst_count", fifo_count, 3);
        check("prerst_valid", rsp_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_count", fifo_count, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_func", alu_func, 0);
        check("rst_data", rsp_data, 0);
        check("rst_flags", rsp_flags, 0);
        check("rst_err", rsp_err, 0);
        check("rst_tag", rsp_tag, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Operation resumes cleanly after reset.
        rsp_ready = 1'b1;
        exp_q.push_back(vecs[4]);
        offer(vecs[4]);
        exp_q.push_back(vecs[5]);
        offer(vecs[5]);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Sequential issue/retire stage wrapped around the 32-bit combinational ALU. Commands (operands, 4-bit function code, tag) are buffered in a small FIFO. The head entry drives the ALU input ports. The ALU result and flags are captured into a registered response slot with a valid/ready handshake. Throughput is one operation per cycle, and the ALU stays purely combinational.

## Interface
Parameters:
- DEPTH, 4 — command FIFO entries; power of two, ≥2
- TAG_W, 4 — width of the caller tag carried alongside each command

Ports:
- clk  in  1  — single clock; all state updates on rising edge
- rst_n  in  1  — asynchronous active-low reset
- cmd_valid  in  1  — command offered
- cmd_ready  out  1  — FIFO can accept a command
- cmd_a  in  32  — operand A
- cmd_b  in  32  — operand B
- cmd_func  in  4  — ALU function code
- cmd_tag  in  TAG_W  — caller tag, returned unchanged
- alu_a  out  32  — to ALU operand a
- alu_b  out  32  — to ALU operand b
- alu_func  out  4  — to ALU func
- alu_res  in  32  — from ALU result
- alu_carry, alu_zr, alu_sign, alu_parity  in  1 each  — from ALU flags
- rsp_valid  out  1  — response held
- rsp_ready  in  1  — consumer accepts response
- rsp_data  out  32  — captured result
- rsp_flags  out  4  — {carry, zr, sign, parity}
- rsp_err  out  1  — divide by zero
- rsp_tag  out  TAG_W  — tag of the response
- fifo_count  out  $clog2(DEPTH)+1  — current FIFO occupancy

## Operation
- Push: cmd_valid & cmd_ready writes {a,b,func,tag} at the tail. cmd_ready = (fifo_count < DEPTH). A same-cycle pop does not free a slot for a push when full.
- ALU drive: when the FIFO is non-empty, alu_a/alu_b/alu_func equal the head entry (combinational from FIFO storage). When empty, they drive 0/0/4'b0000.
- Issue: issue = non-empty & (!rsp_valid | rsp_ready). On issue, the head pops and the response slot loads alu_res, the flags, and the head tag. rsp_valid goes to 1.
- Retire: rsp_valid & rsp_ready with no issue clears rsp_valid. Simultaneous retire and issue reloads the slot and keeps rsp_valid=1.
- Divide by zero: head func 4'b0011 with b==0 gives rsp_err=1, rsp_data=32'hFFFF_FFFF, rsp_flags={0,0,1,1}. The ALU result is ignored.
- Otherwise rsp_err=0 and rsp_flags/rsp_data pass through unmodified.
- Response outputs stay stable while rsp_valid & !rsp_ready.
- Pointers wrap modulo DEPTH. fifo_count is incremented and decremented in one expression, so simultaneous push+pop leaves it unchanged.

## Timing
- Reset (asynchronous, any time, including mid-operation):
  - FIFO emptied, fifo_count=0, pointers=0
  - rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_err=0, rsp_tag=0
  - cmd_ready=1 after reset; alu_* = 0
  - In-flight commands are discarded.
- Latency: a command accepted at edge N is at the FIFO head after N. It issues at edge N+1 if the slot is free, and rsp_valid is high from N+1. Minimum latency is 2 edges.
- Sustained rate: 1 issue/cycle with rsp_ready held high.
- Backpressure: with rsp_ready=0, the slot holds one response and the FIFO fills. cmd_ready drops the cycle after fifo_count reaches DEPTH.
- Full plus pop in one cycle: cmd_ready rises the following cycle.

## Structure
- Package alu_pkg:
  - function-code localparams FUNC_ADD=4'b0000 … FUNC_DIV=4'b0011 … FUNC_EQ=4'b1111
  - flag bit indices FLAG_CARRY=3, FLAG_ZR=2, FLAG_SIGN=1, FLAG_PARITY=0
  - DIV0_RESULT=32'hFFFF_FFFF
- Sub-module alu_cmd_fifo: parameterised synchronous FIFO with async active-low reset, exposing head data, count, push, and pop.
- The top level holds the issue/response register logic and the divide-by-zero override.
- Benches and the top-level integration instantiate the ALU separately and connect alu_* ports.

## Test plan
- Reset then idle: rst_n low mid-stream with 3 entries queued → fifo_count=0, rsp_valid=0, cmd_ready=1, alu_* = 0 immediately.
- Single add: a=5, b=7, func=0000, tag=3 → rsp_valid at 2nd edge, rsp_data=12, flags zr=0 sign=0 parity=1, rsp_tag=3.
- Back-to-back with rsp_ready=1:
  - stimulus: 8 commands, SUB 10-3, XOR FFFF_0000^0F0F_0F0F, …
  - response: one retire per cycle, in order, tags 0..7, rsp_data 7 then F0F0_0F0F.
- Backpressure: rsp_ready=0, push 6 commands → 1 held in the slot, fifo_count=4, cmd_ready=0. Release rsp_ready → all 5 retire in order, with no loss or duplication.
- Divide by zero: a=100, b=0, func=0011 → rsp_err=1, rsp_data=FFFF_FFFF, rsp_flags=4'b0011. The next DIV 100/7 gives 14 with rsp_err=0.
- Compare/equal: func=1111 with a=b=32'h1234 → rsp_data=1. func=1110 with a=2, b=9 → rsp_data=0, zr=1.
